// File: rtl/lsu.sv
// lsu -- load/store unit between the execute stage and the memory port.
// Takes one load or store per request handshake, checks natural alignment,
// drives doubleword-aligned read/write strobes (byte mask, lane-shifted
// write data), extracts and extends load data, and returns one response
// per request.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_wen/addr/size/unsigned request fields (size 0..3 = B/H/W/D)
//   req_wdata                  store data, right-justified
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_misalign   extended load data / misalignment flag
//   mem_raddr/mem_read         read address (addr & ~7) and strobe
//   mem_waddr/wdata/wmask/write write address, shifted data, byte enables, strobe
//   mem_rdata                  read data, valid while mem_read is high
//
// Parameter DELAY (0..15): extra cycles a read is held before sampling.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request
// ACCESS | first memory cycle; store strobes here, load read begins
// WAIT   | DELAY extra cycles; load keeps reading, store idles
// RESP   | response held until resp_ready
module lsu #(
  parameter int unsigned DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] mem_raddr,
  output logic        mem_read,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] DLY = 4'(DELAY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;

  logic        accept;
  logic        misalign;
  logic        last_rd;
  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] ld_val;
  logic [7:0]  base_mask;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign shamt     = {addr_q[2:0], 3'b000};

  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  // Load data is captured on the final read cycle only, so slow memory may
  // present garbage on earlier cycles.
  assign last_rd = !wen_q &&
                   (((state_q == ACCESS) && (DLY == 4'd0)) ||
                    ((state_q == WAIT) && (cnt_q == 4'd1)));

  always_comb begin
    shifted = mem_rdata >> shamt;
    ld_val  = shifted;
    case (size_q)
      2'd0:    ld_val = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    ld_val = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    ld_val = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          rdata_d = 64'd0;
          mis_d   = misalign;
          cnt_d   = DLY;
          state_d = misalign ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (last_rd) rdata_d = ld_val;
        state_d = (DLY == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (last_rd) rdata_d = ld_val;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Outputs decode from the registered state, so an async reset forces
  // every strobe, address and data bus to zero immediately.
  always_comb begin
    mem_read      = !wen_q && ((state_q == ACCESS) || (state_q == WAIT));
    mem_write     = wen_q && (state_q == ACCESS);
    mem_raddr     = mem_read  ? {addr_q[63:3], 3'b000} : 64'd0;
    mem_waddr     = mem_write ? {addr_q[63:3], 3'b000} : 64'd0;
    mem_wdata     = mem_write ? (wdata_q << shamt) : 64'd0;
    mem_wmask     = mem_write ? (base_mask << addr_q[2:0]) : 8'd0;
    resp_valid    = (state_q == RESP);
    resp_rdata    = resp_valid ? rdata_q : 64'd0;
    resp_misalign = resp_valid && mis_q;
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen [2];
  logic [63:0] req_addr [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [63:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_misalign [2];
  logic [63:0] mem_raddr [2];
  logic        mem_read [2];
  logic [63:0] mem_waddr [2];
  logic [63:0] mem_wdata [2];
  logic [7:0]  mem_wmask [2];
  logic        mem_write [2];
  logic [63:0] mem_rdata [2];

  // em: memory seen by each DUT (doublewords), updated from its strobes.
  // mb: byte-level reference memory, updated from the requests themselves.
  logic [63:0] em [2][16];
  logic [7:0]  mb [2][128];

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu #(.DELAY(g * 3)) u_lsu (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_wen       (req_wen[g]),
      .req_addr      (req_addr[g]),
      .req_size      (req_size[g]),
      .req_unsigned  (req_unsigned[g]),
      .req_wdata     (req_wdata[g]),
      .resp_valid    (resp_valid[g]),
      .resp_ready    (resp_ready[g]),
      .resp_rdata    (resp_rdata[g]),
      .resp_misalign (resp_misalign[g]),
      .mem_raddr     (mem_raddr[g]),
      .mem_read      (mem_read[g]),
      .mem_waddr     (mem_waddr[g]),
      .mem_wdata     (mem_wdata[g]),
      .mem_wmask     (mem_wmask[g]),
      .mem_write     (mem_write[g]),
      .mem_rdata     (mem_rdata[g])
    );
    assign mem_rdata[g] = em[g][mem_raddr[g][6:3]];
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(int g, logic [63:0] addr, logic [1:0] size, logic uns);
    int n = 1 << size;
    logic [63:0] v = 64'd0;
    for (int b = 0; b < n; b++)
      v |= 64'(mb[g][(int'(addr[6:0]) + b) % 128]) << (8 * b);
    if (!uns && n < 8 && v[8 * n - 1])
      v |= {64{1'b1}} << (8 * n);
    return v;
  endfunction

  task automatic do_req(int g, bit wen, logic [63:0] addr, logic [1:0] size, bit uns,
                        logic [63:0] wdata, int hold);
    int n, c, nrd, nwr, off;
    bit mis, got, ra_bad, idle_bad;
    logic [63:0] exp_d, ra, held;
    logic [7:0] exp_mask;
    n = 1 << size;
    off = int'(addr[2:0]);
    mis = (addr & 64'(n - 1)) != 64'd0;
    exp_d = (wen || mis) ? 64'd0 : model_load(g, addr, size, uns);
    exp_mask = 8'd0;
    for (int b = 0; b < n; b++) if (off + b < 8) exp_mask[off + b] = 1'b1;
    @(negedge clk);
    req_valid[g] = 1'b1; req_wen[g] = wen; req_addr[g] = addr; req_size[g] = size;
    req_unsigned[g] = uns; req_wdata[g] = wdata; resp_ready[g] = 1'b0;
    chk("req_ready_idle", 64'(req_ready[g]), 64'd1);
    @(negedge clk);
    req_valid[g] = 1'b0;
    c = 1; got = 0; nrd = 0; nwr = 0; ra = 64'd0; ra_bad = 0; idle_bad = 0;
    while (!got && c <= 40) begin
      if (mem_read[g]) begin
        nrd++;
        if (nrd == 1) ra = mem_raddr[g];
        else if (mem_raddr[g] !== ra) ra_bad = 1;
      end else if (mem_raddr[g] !== 64'd0) idle_bad = 1;
      if (mem_write[g]) begin
        nwr++;
        chk("waddr", mem_waddr[g], {addr[63:3], 3'b000});
        chk("wmask", 64'(mem_wmask[g]), 64'(exp_mask));
        chk("wdata", mem_wdata[g], wdata << (8 * off));
        for (int j = 0; j < 8; j++)
          if (mem_wmask[g][j]) em[g][mem_waddr[g][6:3]][8*j +: 8] = mem_wdata[g][8*j +: 8];
      end else if (mem_waddr[g] !== 64'd0 || mem_wdata[g] !== 64'd0 || mem_wmask[g] !== 8'd0)
        idle_bad = 1;
      if (resp_valid[g]) got = 1;
      else begin @(negedge clk); c++; end
    end
    chk("resp_seen", 64'(got), 64'd1);
    chk("latency", 64'(c), mis ? 64'd1 : 64'(2 + 3 * g));
    chk("reads", 64'(nrd), (wen || mis) ? 64'd0 : 64'(1 + 3 * g));
    chk("writes", 64'(nwr), (wen && !mis) ? 64'd1 : 64'd0);
    chk("rdata", resp_rdata[g], exp_d);
    chk("misalign", 64'(resp_misalign[g]), 64'(mis));
    if (!wen && !mis) chk("raddr", ra, {addr[63:3], 3'b000});
    held = resp_rdata[g];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid[g]), 64'd1);
      chk("hold_data", resp_rdata[g], held);
      chk("hold_ready", 64'(req_ready[g]), 64'd0);
      if (mem_read[g] || mem_write[g]) idle_bad = 1;
    end
    resp_ready[g] = 1'b1;
    @(negedge clk);
    resp_ready[g] = 1'b0;
    chk("resp_drop", 64'(resp_valid[g]), 64'd0);
    chk("ready_back", 64'(req_ready[g]), 64'd1);
    chk("raddr_stable", 64'(ra_bad), 64'd0);
    chk("idle_zero", 64'(idle_bad), 64'd0);
    if (wen && !mis)
      for (int b = 0; b < n; b++) mb[g][(int'(addr[6:0]) + b) % 128] = wdata[8*b +: 8];
  endtask

  initial begin
    bit bad;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 0; req_wen[g] = 0; req_addr[g] = 0; req_size[g] = 0;
      req_unsigned[g] = 0; req_wdata[g] = 0; resp_ready[g] = 0;
      for (int k = 0; k < 16; k++) begin
        em[g][k] = (k == 0) ? 64'h1122_3344_8899_AABB : {$urandom, $urandom};
        for (int b = 0; b < 8; b++) mb[g][k * 8 + b] = em[g][k][8*b +: 8];
      end
    end
    #12;
    for (int g = 0; g < 2; g++) begin
      chk("rst_req_ready", 64'(req_ready[g]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[g]), 64'd0);
      chk("rst_resp_rdata", resp_rdata[g], 64'd0);
      chk("rst_mem_strobes", 64'({mem_read[g], mem_write[g]}), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int g = 0; g < 2; g++) begin
      do_req(g, 0, BASE + 1, 2'd0, 0, 64'd0, 0);          // lb
      do_req(g, 0, BASE + 2, 2'd1, 1, 64'd0, 0);          // lhu
      do_req(g, 0, BASE + 4, 2'd2, 0, 64'd0, 0);          // lw
      do_req(g, 0, BASE,     2'd3, 0, 64'd0, 0);          // ld
      do_req(g, 1, BASE + 3, 2'd0, 0, 64'h5A, 0);         // sb
      do_req(g, 0, BASE,     2'd3, 0, 64'd0, 0);          // ld after sb
      do_req(g, 0, BASE + 2, 2'd2, 0, 64'd0, 0);          // misaligned lw
      do_req(g, 0, BASE,     2'd3, 0, 64'd0, 5);          // backpressure
      for (int t = 0; t < 60; t++) begin
        logic [1:0] sz;
        int off;
        sz = 2'($urandom_range(0, 3));
        off = $urandom_range(0, 127);
        if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
        do_req(g, 1'($urandom_range(0, 1)), BASE + 64'(off), sz, 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, $urandom_range(0, 2));
      end
    end

    // Reset during WAIT on the DELAY=3 unit.
    @(negedge clk);
    req_valid[1] = 1; req_wen[1] = 0; req_addr[1] = BASE + 8; req_size[1] = 2'd3;
    @(negedge clk);
    req_valid[1] = 0;
    @(negedge clk);
    chk("rst_pre_read", 64'(mem_read[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_read", 64'(mem_read[1]), 64'd0);
    chk("rst_mid_raddr", mem_raddr[1], 64'd0);
    chk("rst_mid_ready", 64'(req_ready[1]), 64'd1);
    chk("rst_mid_valid", 64'(resp_valid[1]), 64'd0);
    req_valid[1] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_latch", 64'(mem_read[1]), 64'd0);
    req_valid[1] = 0;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid[1] || mem_read[1] || mem_write[1]) bad = 1;
    end
    chk("no_resp_after_rst", 64'(bad), 64'd0);
    do_req(1, 0, BASE + 1, 2'd0, 0, 64'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
